// File: rtl/shift_reg_mm_input.sv
// Serial-to-parallel capture: synchronised serial_in is shifted on a programmable bit
// tick, completed words are queued in a FIFO that the HPS drains over Avalon-MM.
module shift_reg_mm_input #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DIV_RESET = 0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             serial_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [WIDTH-1:0] avs_writedata,
  output logic [WIDTH-1:0] avs_readdata,
  output logic             word_irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam int unsigned DW = 16;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_DIVISOR = 2'd3;

  logic             sync1;
  logic             sync2;
  logic             en;
  logic             irq_en;
  logic             overflow;
  logic [DW-1:0]    divisor;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic [31:0]      wdata;
  logic             unused_wdata;
  logic             wr_control;
  logic             wr_divisor;
  logic             wr_status;
  logic             rd_fifo;
  logic             clear;
  logic [PW-1:0]    level;
  logic             empty;
  logic             full;
  logic             tick;
  logic             word_done;
  logic [WIDTH-1:0] new_word;
  logic             pop;
  logic             push;
  logic             ovf_set;
  logic [31:0]      rd_mux;

  // Register-bus decode; writedata is widened so narrow WIDTH values still expose bit 2.
  assign wdata        = 32'(avs_writedata);
  assign unused_wdata = ^wdata;
  assign wr_control   = avs_write && (avs_address == ADDR_CONTROL);
  assign wr_divisor   = avs_write && (avs_address == ADDR_DIVISOR);
  assign wr_status    = avs_write && (avs_address == ADDR_STATUS);
  assign rd_fifo      = avs_read  && (avs_address == ADDR_DATA);
  assign clear        = wr_control && wdata[2];

  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == PW'(DEPTH));

  assign tick      = en && (div_cnt == divisor);
  assign word_done = tick && (bit_cnt == BW'(WIDTH - 1));
  assign new_word  = {shreg[WIDTH-2:0], sync2};

  // A pop frees the slot a full-FIFO push needs; clear suppresses both.
  assign pop     = rd_fifo && !empty && !clear;
  assign push    = word_done && (!full || pop) && !clear;
  assign ovf_set = word_done && full && !pop && !clear;

  assign word_irq = irq_en && !empty;

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA:    rd_mux = empty ? 32'd0 : 32'(mem[rd_ptr[AW-1:0]]);
      ADDR_STATUS:  rd_mux = {16'd0, 8'(level), 5'd0, overflow, full, empty};
      ADDR_CONTROL: rd_mux = {30'd0, irq_en, en};
      ADDR_DIVISOR: rd_mux = {16'd0, divisor};
      default:      rd_mux = '0;
    endcase
  end

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= serial_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      divisor <= DW'(DIV_RESET);
    end else begin
      if (wr_control) begin
        en     <= wdata[0];
        irq_en <= wdata[1];
      end
      if (wr_divisor) begin
        divisor <= wdata[DW-1:0];
      end
    end
  end

  // Bit-rate divider; a DIVISOR write restarts the count without touching the partial word.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      div_cnt <= '0;
    end else if (clear || !en || wr_divisor || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clear || !en) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (tick) begin
      shreg   <= new_word;
      bit_cnt <= word_done ? '0 : bit_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= new_word;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Sticky overflow: a dropped word wins over a same-cycle write-1-to-clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (wr_status && wdata[2]) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= WIDTH'(rd_mux);
    end
  end

endmodule

// File: tb/tb_shift_reg_mm_input.sv
// Scoreboard bench for shift_reg_mm_input (WIDTH=8, DEPTH=16): reads queue their
// expected data, an independent monitor checks readdata one clock after each read.
module tb_shift_reg_mm_input;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;

  logic             clk_clk = 1'b0;
  logic             reset_reset_n;
  logic             serial_in;
  logic [1:0]       avs_address;
  logic             avs_read;
  logic             avs_write;
  logic [WIDTH-1:0] avs_writedata;
  logic [WIDTH-1:0] avs_readdata;
  logic             word_irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  string      name_q[$];
  logic [7:0] mon_exp;
  string      mon_name;

  shift_reg_mm_input #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_RESET(0)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .serial_in     (serial_in),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .word_irq      (word_irq)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired tests=%0d", n_tests);
    $fatal(1);
  end

  // Read monitor: readdata is valid just after the edge that sampled avs_read.
  always @(posedge clk_clk) begin
    if (avs_read && reset_reset_n) begin
      #1;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read got=0x%02h expected none", avs_readdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (avs_readdata !== mon_exp) begin
          n_fail++;
          $display("FAIL %s got=0x%02h expected=0x%02h", mon_name, avs_readdata, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=0x%02h expected=0x%02h", nm, got, expv);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk_clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] expv, input string nm);
    @(negedge clk_clk);
    avs_address = a; avs_read = 1'b1;
    exp_q.push_back(expv); name_q.push_back(nm);
    @(negedge clk_clk);
    avs_read = 1'b0;
  endtask

  // Sends one MSB-first byte, each bit held d+1 clocks; en is raised one clock after
  // the first bit so the first tick lands on it, and dropped just after the push.
  task automatic send(input logic [7:0] w, input int d, input bit rd_at_push,
                      input logic [7:0] rd_exp);
    int n;
    n = 8 * (d + 1);
    for (int c = 0; c <= n + 2; c++) begin
      @(negedge clk_clk);
      avs_write = 1'b0; avs_read = 1'b0;
      serial_in = (c < n) ? w[7 - c / (d + 1)] : 1'b0;
      if (c == 1) begin
        avs_address = 2'd2; avs_writedata = 8'h03; avs_write = 1'b1;
      end
      if (c == n + 1 && rd_at_push) begin
        avs_address = 2'd0; avs_read = 1'b1;
        exp_q.push_back(rd_exp); name_q.push_back("t4_read_at_push");
      end
      if (c == n + 2) begin
        avs_address = 2'd2; avs_writedata = 8'h02; avs_write = 1'b1;
      end
    end
    @(negedge clk_clk);
    avs_write = 1'b0; avs_read = 1'b0;
  endtask

  initial begin
    logic [4:0] part;
    reset_reset_n = 1'b0;
    serial_in     = 1'b0;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;

    // Reset state
    chk("rst_readdata", avs_readdata, 8'h00);
    chk("rst_irq", {7'd0, word_irq}, 8'h00);
    rd(2'd1, 8'h01, "rst_status");
    rd(2'd2, 8'h00, "rst_control");
    rd(2'd3, 8'h00, "rst_divisor");
    rd(2'd0, 8'h00, "rst_data_empty");

    // T1: one bit per clock
    send(8'hA5, 0, 1'b0, 8'h00);
    chk("t1_irq_set", {7'd0, word_irq}, 8'h01);
    rd(2'd1, 8'h00, "t1_status_one");
    rd(2'd0, 8'hA5, "t1_data");
    rd(2'd1, 8'h01, "t1_status_empty");
    chk("t1_irq_clr", {7'd0, word_irq}, 8'h00);

    // T2: four clocks per bit
    wr(2'd3, 8'h03);
    rd(2'd3, 8'h03, "t2_divisor");
    send(8'h3C, 3, 1'b0, 8'h00);
    rd(2'd1, 8'h00, "t2_status_one");
    rd(2'd0, 8'h3C, "t2_data");
    rd(2'd1, 8'h01, "t2_status_empty");
    wr(2'd3, 8'h00);

    // T3: overflow drops the 17th word
    for (int i = 1; i <= 16; i++) send(8'(i), 0, 1'b0, 8'h00);
    rd(2'd1, 8'h02, "t3_status_full");
    send(8'hFF, 0, 1'b0, 8'h00);
    rd(2'd1, 8'h06, "t3_status_ovf");
    for (int i = 1; i <= 16; i++) rd(2'd0, 8'(i), "t3_data");
    rd(2'd1, 8'h05, "t3_status_drained");
    @(negedge clk_clk);
    avs_address = 2'd1; avs_read = 1'b1; avs_write = 1'b1; avs_writedata = 8'h04;
    exp_q.push_back(8'h05); name_q.push_back("t3_rw_prewrite");
    @(negedge clk_clk);
    avs_read = 1'b0; avs_write = 1'b0;
    rd(2'd1, 8'h01, "t3_ovf_cleared");

    // T4: pop on the cycle the 17th word lands
    for (int i = 1; i <= 16; i++) send(8'(i), 0, 1'b0, 8'h00);
    send(8'hEE, 0, 1'b1, 8'h01);
    rd(2'd1, 8'h02, "t4_status_full_no_ovf");
    for (int i = 2; i <= 16; i++) rd(2'd0, 8'(i), "t4_data");
    rd(2'd0, 8'hEE, "t4_new_word");
    rd(2'd1, 8'h01, "t4_status_empty");

    // T5: disable mid-word discards the partial word, then clear flushes
    part = 5'b10110;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk_clk);
      avs_write = 1'b0;
      serial_in = (c < 5) ? part[4 - c] : 1'b0;
      if (c == 1) begin avs_address = 2'd2; avs_writedata = 8'h03; avs_write = 1'b1; end
      if (c == 6) begin avs_address = 2'd2; avs_writedata = 8'h02; avs_write = 1'b1; end
    end
    @(negedge clk_clk);
    avs_write = 1'b0;
    send(8'h81, 0, 1'b0, 8'h00);
    send(8'h42, 0, 1'b0, 8'h00);
    rd(2'd0, 8'h81, "t5_first_word");
    wr(2'd2, 8'h06);
    rd(2'd1, 8'h01, "t5_status_cleared");
    rd(2'd2, 8'h02, "t5_control");
    chk("t5_irq", {7'd0, word_irq}, 8'h00);
    rd(2'd0, 8'h00, "t5_empty_read");

    // T6: reset mid-word with words queued
    send(8'h11, 0, 1'b0, 8'h00);
    send(8'h22, 0, 1'b0, 8'h00);
    send(8'h33, 0, 1'b0, 8'h00);
    wr(2'd3, 8'h05);
    rd(2'd3, 8'h05, "t6_divisor_set");
    chk("t6_irq_before", {7'd0, word_irq}, 8'h01);
    wr(2'd2, 8'h03);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk_clk);
      serial_in = c[0];
    end
    reset_reset_n = 1'b0;
    #1;
    chk("t6_readdata_in_reset", avs_readdata, 8'h00);
    chk("t6_irq_in_reset", {7'd0, word_irq}, 8'h00);
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    serial_in = 1'b0;
    rd(2'd1, 8'h01, "t6_status");
    rd(2'd0, 8'h00, "t6_data_empty");
    rd(2'd3, 8'h00, "t6_divisor_reset");
    rd(2'd2, 8'h00, "t6_control_reset");
    chk("t6_irq_after", {7'd0, word_irq}, 8'h00);

    repeat (3) @(negedge clk_clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
